// File: rtl/overdrive_pipe.sv
// overdrive_pipe: three-stage gain / clip shaper for signed audio samples.
//   S1 multiplies the accepted sample by the current (ramped) gain.
//   S2 shapes the product: bypass saturate, hard clip, or soft clip.
//   S3 registers the output and counts clipped samples.
// Handshake: valid-only. A sample is accepted on every rising edge where
// in_valid=1; there is no ready, so the pipeline never stalls and out_valid
// follows in_valid exactly three cycles later, in order.
module overdrive_pipe #(
    parameter int DATA_W    = 16,
    parameter int GAIN_FRAC = 12,
    parameter int THRESH    = 2 ** (DATA_W - 2),
    parameter int RAMP_STEP = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic signed [15:0]       gain_target,
    input  logic [1:0]               mode,
    input  logic                     clip_clr,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic [15:0]              clip_count
);

    localparam int PW = DATA_W + 16;

    localparam logic signed [15:0]       G_UNITY = 16'(2 ** GAIN_FRAC);
    localparam logic signed [16:0]       STEP    = 17'(RAMP_STEP);
    localparam logic signed [PW-1:0]     P_THR   = PW'(THRESH);
    localparam logic signed [PW-1:0]     P_MAX   = {{(PW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PW-1:0]     P_MIN   = ~P_MAX;
    localparam logic signed [DATA_W-1:0] Y_MAX   = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN   = {1'b1, {(DATA_W - 1){1'b0}}};

    // Gain ramp state
    logic signed [15:0]       r_g_cur;

    // S1 registers
    logic                     r_s1_valid;
    logic signed [PW-1:0]     r_s1_p;
    logic [1:0]               r_s1_mode;

    // S2 registers
    logic                     r_s2_valid;
    logic signed [DATA_W-1:0] r_s2_y;
    logic                     r_s2_clip;

    // S1 combinational: full-width product, arithmetic shift, gain step
    logic signed [PW-1:0]     w_in_ext;
    logic signed [PW-1:0]     w_g_ext;
    logic signed [PW-1:0]     w_prod;
    logic signed [PW-1:0]     w_p;
    logic signed [16:0]       w_diff;
    logic signed [15:0]       w_g_next;

    // S2 combinational: shaping
    logic signed [PW-1:0]     w_abs;
    logic signed [PW-1:0]     w_soft_mag;
    logic signed [PW-1:0]     w_soft;
    logic signed [PW-1:0]     w_pre;
    logic signed [DATA_W-1:0] w_y;
    logic                     w_clip;

    assign w_in_ext = {{16{in_sample[DATA_W-1]}}, in_sample};
    assign w_g_ext  = {{DATA_W{r_g_cur[15]}}, r_g_cur};
    assign w_prod   = w_in_ext * w_g_ext;
    assign w_p      = w_prod >>> GAIN_FRAC;
    assign w_diff   = {gain_target[15], gain_target} - {r_g_cur[15], r_g_cur};

    // Move the gain toward the target by at most RAMP_STEP, snapping when close
    always_comb begin
        w_g_next = gain_target;
        if (w_diff > STEP) begin
            w_g_next = r_g_cur + 16'(RAMP_STEP);
        end else if (w_diff < -STEP) begin
            w_g_next = r_g_cur - 16'(RAMP_STEP);
        end
    end

    // Gain register advances only on accepted samples; the product above used the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g_cur <= G_UNITY;
        end else if (in_valid) begin
            r_g_cur <= w_g_next;
        end
    end

    // S1: capture scaled product and the mode that travels with this sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_mode  <= 2'd0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_p    <= w_p;
                r_s1_mode <= mode;
            end
        end
    end

    assign w_abs      = r_s1_p[PW-1] ? -r_s1_p : r_s1_p;
    assign w_soft_mag = P_THR + ((w_abs - P_THR) >>> 2);
    assign w_soft     = r_s1_p[PW-1] ? -w_soft_mag : w_soft_mag;

    // Shape per mode, then saturate to the output width; clipped means the result moved off p
    always_comb begin
        w_pre = r_s1_p;
        case (r_s1_mode)
            2'd0: w_pre = r_s1_p;
            2'd2: begin
                if (w_abs > P_THR) begin
                    w_pre = w_soft;
                end
            end
            default: begin
                if (r_s1_p > P_THR) begin
                    w_pre = P_THR;
                end else if (r_s1_p < -P_THR) begin
                    w_pre = -P_THR;
                end
            end
        endcase
        if (w_pre > P_MAX) begin
            w_y = Y_MAX;
        end else if (w_pre < P_MIN) begin
            w_y = Y_MIN;
        end else begin
            w_y = w_pre[DATA_W-1:0];
        end
        w_clip = ({{16{w_y[DATA_W-1]}}, w_y} != r_s1_p);
    end

    // S2: register shaped sample and its clip flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_clip  <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y    <= w_y;
                r_s2_clip <= w_clip;
            end
        end
    end

    // S3: output register holds its last value between valid samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                out_sample <= r_s2_y;
            end
        end
    end

    // Saturating clip counter; a clear on the same edge as a clipped output wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_count <= 16'd0;
        end else if (clip_clr) begin
            clip_count <= 16'd0;
        end else if (r_s2_valid && r_s2_clip && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_overdrive_pipe.sv
// Directed bench for overdrive_pipe: hand-computed vectors through an
// expected-value queue, plus latency, clip counter, hold and reset checks.
module tb_overdrive_pipe;

    localparam int DATA_W = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_sample;
    logic signed [15:0]       gain_target;
    logic [1:0]               mode;
    logic                     clip_clr;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_sample;
    logic [15:0]              clip_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic signed [DATA_W-1:0] exp_q[$];

    overdrive_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_sample   (in_sample),
        .gain_target (gain_target),
        .mode        (mode),
        .clip_clr    (clip_clr),
        .out_valid   (out_valid),
        .out_sample  (out_sample),
        .clip_count  (clip_count)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one accepted sample; called at posedge+1, returns at next posedge+1
    task automatic send(input logic signed [DATA_W-1:0] s, input logic [1:0] m,
                        input logic signed [DATA_W-1:0] e);
        in_valid  = 1'b1;
        in_sample = s;
        mode      = m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("drain_q", exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        clip_clr = 1'b1;
        @(posedge clk);
        #1;
        clip_clr = 1'b0;
    endtask

    // Single pulse already sent; out_valid must show on the 3rd cycle only
    task automatic check_latency(input string tag);
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq(tag, out_valid, (k == 3) ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid output pops the next expected value
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 1, 0);
            end else begin
                check_eq("out_sample", out_sample, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_sample   = '0;
        gain_target = 16'sd4096;
        mode        = 2'd0;
        clip_clr    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_sample", out_sample, 0);
        check_eq("rst_clip_count", clip_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unity gain single pulse with latency
        send(16'sd1000, 2'd0, 16'sd1000);
        check_latency("lat_unity");
        check_eq("unity_clip_count", clip_count, 0);

        // Gain ramp from unity toward 4136: products use 4096, 4112, 4128, then 4136
        gain_target = 16'sd4136;
        send(16'sd1000, 2'd0, 16'sd1000);
        send(16'sd1000, 2'd0, 16'sd1003);
        send(16'sd1000, 2'd0, 16'sd1007);
        send(-16'sd1000, 2'd0, -16'sd1010);
        drain();

        // Ramp back down to unity: 4120, 4104, then snap to 4096
        gain_target = 16'sd4096;
        repeat (4) send(16'sd0, 2'd0, 16'sd0);
        drain();

        // Hard clip (modes 1 and 3), soft clip (mode 2), bypass (mode 0), back to back
        send(16'sd20000, 2'd1, 16'sd16384);
        send(-16'sd20000, 2'd1, -16'sd16384);
        send(16'sd16384, 2'd1, 16'sd16384);
        send(-16'sd16384, 2'd1, -16'sd16384);
        send(16'sd20000, 2'd3, 16'sd16384);
        send(16'sd20000, 2'd2, 16'sd17288);
        send(16'sd32767, 2'd2, 16'sd20479);
        send(-16'sd32767, 2'd2, -16'sd20479);
        send(-16'sd32768, 2'd2, -16'sd20480);
        send(16'sd16384, 2'd2, 16'sd16384);
        send(16'sd16385, 2'd2, 16'sd16384);
        send(-16'sd32768, 2'd0, -16'sd32768);
        send(16'sd32767, 2'd0, 16'sd32767);
        drain();
        check_eq("mode_clip_count", clip_count, 8);

        pulse_clr();
        check_eq("clr_alone", clip_count, 0);

        // Bypass saturation at gain 2.0 (256 ramp steps of 16)
        gain_target = 16'sd8192;
        repeat (256) send(16'sd0, 2'd0, 16'sd0);
        send(16'sd20000, 2'd0, 16'sd32767);
        send(-16'sd20000, 2'd0, -16'sd32768);
        send(16'sd10000, 2'd0, 16'sd20000);
        drain();
        check_eq("sat_clip_count", clip_count, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("hold_sample", out_sample, 20000);
            check_eq("hold_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Counter saturation at unity gain
        gain_target = 16'sd4096;
        repeat (256) send(16'sd0, 2'd0, 16'sd0);
        drain();
        pulse_clr();
        for (int i = 0; i < 65536; i++) send(16'sd20000, 2'd1, 16'sd16384);
        drain();
        check_eq("count_saturate", clip_count, 65535);

        // Clear coinciding with a clipped output
        pulse_clr();
        check_eq("clr_after_sat", clip_count, 0);
        send(16'sd20000, 2'd1, 16'sd16384);
        drain();
        check_eq("count_one", clip_count, 1);
        send(16'sd20000, 2'd1, 16'sd16384);
        in_valid = 1'b0;
        @(posedge clk);
        #1 clip_clr = 1'b1;
        @(posedge clk);
        #1 clip_clr = 1'b0;
        drain();
        check_eq("clr_wins", clip_count, 0);

        // Reset mid-stream with two samples in flight
        send(16'sd20000, 2'd1, 16'sd16384);
        drain();
        check_eq("pre_rst_count", clip_count, 1);
        gain_target = 16'sd4136;
        send(16'sd20000, 2'd1, 16'sd0);
        send(16'sd20000, 2'd1, 16'sd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("midrst_valid", out_valid, 0);
            check_eq("midrst_count", clip_count, 0);
            check_eq("midrst_sample", out_sample, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("post_rst_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;
        // Gain back at unity: first post-reset sample is unscaled
        send(16'sd1000, 2'd0, 16'sd1000);
        check_latency("lat_post_rst");
        check_eq("post_rst_count", clip_count, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
